aes_bram_ctrl: RTL and testbench

AES_BRAM_CTRL -- requirements
Module: aes_bram_ctrl

---
 rtl/aes_bram_ctrl.sv | 157 +++++++++++++++
 tb/tb_aes_bram_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_bram_ctrl.sv
// Single-port BRAM sequencer for the AES core: turns read/write request levels into
// one BRAM access each, with edge re-arming, read-over-write priority and counters.
module aes_bram_ctrl #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 aes_clk,
    input  logic                 aes_rst,
    input  logic                 aes_start_read,
    input  logic [31:0]          aes_bram_addr,
    input  logic                 aes_start_write,
    input  logic [31:0]          aes_bram_write_addr,
    input  logic [31:0]          aes_bram_write_data,
    output logic                 bram_complete,
    output logic [31:0]          aes_bram_read_data,
    output logic                 bram_en,
    output logic [3:0]           bram_we,
    output logic [31:0]          bram_addr,
    output logic [31:0]          bram_wrdata,
    input  logic [31:0]          bram_rddata,
    output logic                 addr_misaligned,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdWait,
        StRdDone,
        StWrIssue,
        StWrDone
    } state_t;

    localparam logic [1:0]           LastWait = 2'(READ_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

    state_t      state;
    logic [1:0]  wait_cnt;
    logic        rd_arm;
    logic        wr_arm;
    logic        wr_pend;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        rd_ok;
    logic        wr_ok;

    always_comb begin
        rd_ok = (state == StIdle) && aes_start_read && rd_arm;
        wr_ok = (state == StIdle) && aes_start_write && wr_arm;
    end

    always_ff @(posedge aes_clk) begin
        if (aes_rst) begin
            state              <= StIdle;
            wait_cnt           <= 2'd0;
            rd_arm             <= 1'b1;
            wr_arm             <= 1'b1;
            wr_pend            <= 1'b0;
            wr_addr_q          <= 32'h0;
            wr_data_q          <= 32'h0;
            bram_complete      <= 1'b0;
            aes_bram_read_data <= 32'h0;
            bram_en            <= 1'b0;
            bram_we            <= 4'h0;
            bram_addr          <= 32'h0;
            bram_wrdata        <= 32'h0;
            addr_misaligned    <= 1'b0;
            rd_count           <= '0;
            wr_count           <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    bram_complete <= 1'b0;
                    // A write that lost arbitration to a read goes first once idle again.
                    if (wr_pend) begin
                        wr_pend     <= 1'b0;
                        bram_en     <= 1'b1;
                        bram_we     <= 4'hF;
                        bram_addr   <= {wr_addr_q[31:2], 2'b00};
                        bram_wrdata <= wr_data_q;
                        state       <= StWrIssue;
                    end else if (rd_ok) begin
                        rd_arm    <= 1'b0;
                        bram_en   <= 1'b1;
                        bram_we   <= 4'h0;
                        bram_addr <= {aes_bram_addr[31:2], 2'b00};
                        state     <= StRdIssue;
                        if (aes_bram_addr[1:0] != 2'b00) addr_misaligned <= 1'b1;
                        // Losing write is latched now so later input changes cannot leak in.
                        if (wr_ok) begin
                            wr_arm    <= 1'b0;
                            wr_pend   <= 1'b1;
                            wr_addr_q <= aes_bram_write_addr;
                            wr_data_q <= aes_bram_write_data;
                            if (aes_bram_write_addr[1:0] != 2'b00) addr_misaligned <= 1'b1;
                        end
                    end else if (wr_ok) begin
                        wr_arm      <= 1'b0;
                        bram_en     <= 1'b1;
                        bram_we     <= 4'hF;
                        bram_addr   <= {aes_bram_write_addr[31:2], 2'b00};
                        bram_wrdata <= aes_bram_write_data;
                        state       <= StWrIssue;
                        if (aes_bram_write_addr[1:0] != 2'b00) addr_misaligned <= 1'b1;
                    end
                end
                StRdIssue: begin
                    bram_en  <= 1'b0;
                    wait_cnt <= 2'd0;
                    state    <= StRdWait;
                end
                StRdWait: begin
                    if (wait_cnt == LastWait) begin
                        aes_bram_read_data <= bram_rddata;
                        bram_complete      <= 1'b1;
                        bram_addr          <= 32'h0;
                        if (rd_count != CntMax) rd_count <= rd_count + CntOne;
                        state              <= StRdDone;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                StRdDone: begin
                    bram_complete <= 1'b0;
                    state         <= StIdle;
                end
                StWrIssue: begin
                    bram_en       <= 1'b0;
                    bram_we       <= 4'h0;
                    bram_addr     <= 32'h0;
                    bram_wrdata   <= 32'h0;
                    bram_complete <= 1'b1;
                    if (wr_count != CntMax) wr_count <= wr_count + CntOne;
                    state         <= StWrDone;
                end
                StWrDone: begin
                    bram_complete <= 1'b0;
                    state         <= StIdle;
                end
                default: begin
                    bram_complete <= 1'b0;
                    bram_en       <= 1'b0;
                    bram_we       <= 4'h0;
                    bram_addr     <= 32'h0;
                    state         <= StIdle;
                end
            endcase

            // Accept only happens with the line high, so these never collide with a clear.
            if (!aes_start_read) rd_arm <= 1'b1;
            if (!aes_start_write) wr_arm <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_bram_ctrl.sv
// Directed bench for aes_bram_ctrl with a two-cycle-latency BRAM model.
module tb_aes_bram_ctrl;

    logic        clk;
    logic        rst;
    logic        start_read;
    logic [31:0] rd_addr;
    logic        start_write;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        complete;
    logic [31:0] rdata;
    logic        en;
    logic [3:0]  we;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] brdata;
    logic        misaligned;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:63];
    logic [31:0] p1;

    aes_bram_ctrl #(
        .READ_LATENCY(2),
        .CNT_WIDTH   (16)
    ) dut (
        .aes_clk            (clk),
        .aes_rst            (rst),
        .aes_start_read     (start_read),
        .aes_bram_addr      (rd_addr),
        .aes_start_write    (start_write),
        .aes_bram_write_addr(wr_addr),
        .aes_bram_write_data(wr_data),
        .bram_complete      (complete),
        .aes_bram_read_data (rdata),
        .bram_en            (en),
        .bram_we            (we),
        .bram_addr          (baddr),
        .bram_wrdata        (bwdata),
        .bram_rddata        (brdata),
        .addr_misaligned    (misaligned),
        .rd_count           (rd_count),
        .wr_count           (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM: contents reload on reset; read data appears two cycles after the enable.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 4) ? 32'hDEADBEEF : (32'hA5A50000 | i);
            p1     <= 32'h0;
            brdata <= 32'h0;
        end else begin
            if (en && we == 4'hF) mem[baddr[7:2]] <= bwdata;
            p1     <= en ? mem[baddr[7:2]] : 32'h0;
            brdata <= p1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_complete"}, {31'h0, complete}, 32'h0);
        chk({tag, "_en"}, {31'h0, en}, 32'h0);
        chk({tag, "_we"}, {28'h0, we}, 32'h0);
        chk({tag, "_addr"}, baddr, 32'h0);
        chk({tag, "_wrdata"}, bwdata, 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_misal"}, {31'h0, misaligned}, 32'h0);
        chk({tag, "_rdcnt"}, {16'h0, rd_count}, 32'h0);
        chk({tag, "_wrcnt"}, {16'h0, wr_count}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        start_read = 1'b0;
        start_write = 1'b0;
        rd_addr = 32'h0;
        wr_addr = 32'h0;
        wr_data = 32'h0;
        tick();
        tick();
        chk_reset_outs("reset");
        rst = 1'b0;
        tick();

        // Single read at 0x10, latency 2: enable in cycle 1, complete in cycle 4.
        start_read = 1'b1;
        rd_addr = 32'h10;
        tick();
        chk("rd1_c1_en", {31'h0, en}, 32'h1);
        chk("rd1_c1_we", {28'h0, we}, 32'h0);
        chk("rd1_c1_addr", baddr, 32'h10);
        rd_addr = 32'hFFFF_FFF0;
        tick();
        chk("rd1_c2_en", {31'h0, en}, 32'h0);
        chk("rd1_c2_addr", baddr, 32'h10);
        tick();
        chk("rd1_c3_cmp", {31'h0, complete}, 32'h0);
        tick();
        chk("rd1_c4_cmp", {31'h0, complete}, 32'h1);
        chk("rd1_c4_data", rdata, 32'hDEADBEEF);
        chk("rd1_c4_cnt", {16'h0, rd_count}, 32'h1);
        chk("rd1_c4_addr", baddr, 32'h0);
        // Request held high: no second access.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rd1_hold_en", {31'h0, en}, 32'h0);
            chk("rd1_hold_cmp", {31'h0, complete}, 32'h0);
        end
        chk("rd1_hold_cnt", {16'h0, rd_count}, 32'h1);
        start_read = 1'b0;

        // Four-word burst with drop/re-raise between words.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            start_read = 1'b0;
            tick();
            start_read = 1'b1;
            rd_addr = 32'(k * 4);
            tick();
            chk("burst_en", {31'h0, en}, 32'h1);
            chk("burst_addr", baddr, 32'(k * 4));
            tick();
            tick();
            tick();
            chk("burst_cmp", {31'h0, complete}, 32'h1);
            chk("burst_data", rdata, 32'hA5A50000 | 32'(k));
        end
        chk("burst_cnt", {16'h0, rd_count}, 32'h4);
        start_read = 1'b0;
        tick();

        // Simultaneous read (0x8) and write (0x20): read first, write data from cycle 0.
        start_read = 1'b1;
        rd_addr = 32'h8;
        start_write = 1'b1;
        wr_addr = 32'h20;
        wr_data = 32'hCAFEF00D;
        tick();
        wr_addr = 32'h40;
        wr_data = 32'h0;
        chk("sim_c1_en", {31'h0, en}, 32'h1);
        chk("sim_c1_we", {28'h0, we}, 32'h0);
        chk("sim_c1_addr", baddr, 32'h8);
        tick();
        tick();
        tick();
        chk("sim_c4_cmp", {31'h0, complete}, 32'h1);
        chk("sim_c4_data", rdata, 32'hA5A50002);
        tick();
        chk("sim_c5_en", {31'h0, en}, 32'h0);
        chk("sim_c5_cmp", {31'h0, complete}, 32'h0);
        tick();
        chk("sim_c6_en", {31'h0, en}, 32'h1);
        chk("sim_c6_we", {28'h0, we}, 32'hF);
        chk("sim_c6_addr", baddr, 32'h20);
        chk("sim_c6_wdata", bwdata, 32'hCAFEF00D);
        tick();
        chk("sim_c7_cmp", {31'h0, complete}, 32'h1);
        chk("sim_c7_wrcnt", {16'h0, wr_count}, 32'h1);
        chk("sim_c7_rdcnt", {16'h0, rd_count}, 32'h5);
        chk("sim_c7_rdata", rdata, 32'hA5A50002);
        chk("sim_c7_mem", mem[8], 32'hCAFEF00D);
        chk("sim_c7_we", {28'h0, we}, 32'h0);
        tick();
        chk("sim_c8_cmp", {31'h0, complete}, 32'h0);
        chk("sim_c8_en", {31'h0, en}, 32'h0);
        chk("sim_misal0", {31'h0, misaligned}, 32'h0);
        start_read = 1'b0;
        start_write = 1'b0;
        tick();

        // Misaligned write to 0x13 lands on word 0x10; flag is sticky.
        start_write = 1'b1;
        wr_addr = 32'h13;
        wr_data = 32'h12345678;
        tick();
        chk("mis_addr", baddr, 32'h10);
        chk("mis_we", {28'h0, we}, 32'hF);
        chk("mis_wdata", bwdata, 32'h12345678);
        chk("mis_flag", {31'h0, misaligned}, 32'h1);
        tick();
        chk("mis_cmp", {31'h0, complete}, 32'h1);
        start_write = 1'b0;
        start_read = 1'b1;
        rd_addr = 32'h10;
        tick();
        tick();
        chk("mis_rd_en", {31'h0, en}, 32'h1);
        tick();
        tick();
        tick();
        chk("mis_rd_cmp", {31'h0, complete}, 32'h1);
        chk("mis_rd_data", rdata, 32'h12345678);
        chk("mis_sticky", {31'h0, misaligned}, 32'h1);
        start_read = 1'b0;
        tick();

        // Reset during RD_WAIT aborts silently; a fresh read then runs normally.
        start_read = 1'b1;
        rd_addr = 32'h0;
        tick();
        chk("abort_c1_en", {31'h0, en}, 32'h1);
        tick();
        rst = 1'b1;
        tick();
        chk_reset_outs("abort");
        rst = 1'b0;
        start_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_quiet_cmp", {31'h0, complete}, 32'h0);
            chk("abort_quiet_en", {31'h0, en}, 32'h0);
        end
        start_read = 1'b1;
        rd_addr = 32'hC;
        tick();
        chk("fresh_c1_en", {31'h0, en}, 32'h1);
        chk("fresh_c1_addr", baddr, 32'hC);
        tick();
        tick();
        chk("fresh_c3_cmp", {31'h0, complete}, 32'h0);
        tick();
        chk("fresh_c4_cmp", {31'h0, complete}, 32'h1);
        chk("fresh_c4_data", rdata, 32'hA5A50003);
        chk("fresh_c4_cnt", {16'h0, rd_count}, 32'h1);
        tick();
        chk("fresh_c5_cmp", {31'h0, complete}, 32'h0);
        start_read = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
